// File: rtl/tick_pwm.sv
// Tick-driven PWM generator with a one-deep shadowed configuration.
// state | meaning
// IDLE  | stopped, output low, new config applied immediately
// RUN   | generating; counts ticks within the period
// STOP  | still generating, returns to IDLE at the end of this period
module tick_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] period_r, period_nx, duty_r, duty_nx;
  logic [WIDTH-1:0] sh_period, sh_duty;
  logic [WIDTH-1:0] p_eff, p_last;
  logic             sh_full, sh_full_nx;
  logic             accept, wrap, busy_nx, pwm_nx;

  assign cfg_ready = ~sh_full;
  assign accept    = cfg_valid & ~sh_full;
  // A programmed period of zero behaves as a one-tick period.
  assign p_eff     = (period_r == '0) ? WIDTH'(1) : period_r;
  assign p_last    = p_eff - WIDTH'(1);
  assign wrap      = (state != IDLE) && tick && (cnt >= p_last);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    period_nx  = period_r;
    duty_nx    = duty_r;
    sh_full_nx = sh_full;

    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (!start) state_nx = STOP;
      STOP: begin
        if (start)     state_nx = RUN;
        else if (wrap) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (state == IDLE)  cnt_nx = '0;
    else if (tick)      cnt_nx = wrap ? '0 : cnt + WIDTH'(1);

    // Shadow only lands between periods; a same-cycle accept stays in the shadow.
    if (sh_full && ((state == IDLE) || wrap)) begin
      period_nx  = sh_period;
      duty_nx    = sh_duty;
      sh_full_nx = 1'b0;
    end
    if (accept) sh_full_nx = 1'b1;

    busy_nx = (state_nx != IDLE);
    pwm_nx  = busy_nx && (cnt_nx < duty_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      period_r    <= '0;
      duty_r      <= '0;
      sh_period   <= '0;
      sh_duty     <= '0;
      sh_full     <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      period_r    <= period_nx;
      duty_r      <= duty_nx;
      sh_full     <= sh_full_nx;
      pwm_out     <= pwm_nx;
      period_done <= wrap;
      busy        <= busy_nx;
      if (accept) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
      end
    end
  end

endmodule

// File: doc/tick_pwm.md
TICK_PWM -- requirements
Module: tick_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of the period, duty and internal tick counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port tick  input  1  one-cycle advance strobe from the upstream frequency divider, asserted on its count wrap.
REQ-005 SHALL have port start  input  1  level run request; high = generate, low = stop at the next period boundary.
REQ-006 SHALL have port cfg_valid  input  1  new configuration offered.
REQ-007 SHALL have port cfg_ready  output  1  shadow register empty; a configuration can be accepted.
REQ-008 SHALL have port cfg_period  input  WIDTH  ticks per PWM period.
REQ-009 SHALL have port cfg_duty  input  WIDTH  ticks per period that pwm_out is high.
REQ-010 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-011 SHALL have port period_done  output  1  one-cycle pulse at each completed period.
REQ-012 SHALL have port busy  output  1  high in RUN or STOP state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP.
REQ-014 IDLE -> RUN on the cycle start=1; cnt SHALL be 0 on entry to RUN.
REQ-015 RUN -> STOP when start=0; STOP -> RUN when start=1 again, with no restart of cnt.
REQ-016 STOP -> IDLE on the tick that completes the current period; period_done SHALL still pulse on that tick.
REQ-017 cnt SHALL advance only in RUN or STOP and only on cycles with tick=1; tick is ignored in IDLE.
REQ-018 Effective period P = max(period_r, 1); on tick with cnt = P-1, cnt SHALL wrap to 0 and period_done SHALL be 1 in the following cycle only.
REQ-019 pwm_out SHALL be registered: next value = 1 when busy (next state) and cnt_next < duty_r, else 0.
REQ-020 duty_r = 0 SHALL give constant low; duty_r >= P SHALL give constant high while busy.
REQ-021 Handshake: config accepted into shadow when cfg_valid=1 and cfg_ready=1 in the same cycle; cfg_ready SHALL drop in the next cycle and stay low while the shadow is full.
REQ-022 In IDLE, a shadowed config SHALL transfer to period_r/duty_r in the cycle after acceptance, and cfg_ready SHALL return high in that same cycle.
REQ-023 In RUN/STOP, the shadow SHALL transfer only at a period wrap (REQ-018), so a period is never altered mid-flight; cfg_ready SHALL return high the cycle after the transfer.
REQ-024 Simultaneous acceptance and wrap: the newly accepted values SHALL go into the shadow only; the transfer at that wrap uses the prior shadow contents if full, otherwise none.
REQ-025 cfg_valid while cfg_ready=0 SHALL be ignored, with no stall or corruption.
REQ-026 All arithmetic SHALL be unsigned WIDTH-bit; cnt never exceeds P-1.

Reset
REQ-027 With rst_n=0 at a clk edge: state=IDLE, cnt=0, period_r=0, duty_r=0, shadow empty, pwm_out=0, period_done=0, busy=0, cfg_ready=1.
REQ-028 Reset mid-operation SHALL take priority over tick, start and cfg_valid in the same cycle and discard any pending shadow.

Verification
REQ-029 Config period=3 duty=1 in IDLE, start=1, tick every 3rd cycle -> pwm_out high 1 tick and low 2 ticks per period; period_done pulses every 9 cycles.
REQ-030 While running period=4 duty=2, accept period=2 duty=1 mid-period -> current period completes as 4/2, the next is 2/1, and cfg_ready is low until the wrap.
REQ-031 Drop start at cnt=1 of period=4 -> busy stays high until the wrap tick; period_done pulses once; then IDLE with pwm_out=0.
REQ-032 duty=0 then duty=5 with period=4 -> pwm_out is constant 0, then constant 1 while busy; period=0 behaves as period=1.
REQ-033 Assert rst_n=0 with tick=1 and cfg_valid=1 mid-period -> all outputs take their REQ-027 values next cycle; the pending config is lost.
REQ-034 Hold cfg_valid with cfg_ready=0 for multiple cycles -> only the first accepted config takes effect.
